// File: rtl/debug_dump_pkg.sv
// Shared types and constants for the debug dump sequencer and its word serializer.
package debug_dump_pkg;

   localparam int WORD_BYTES      = 4;
   localparam int NB_BYTE         = 8;
   localparam int NB_WORD         = WORD_BYTES * NB_BYTE;
   localparam int NB_REGFILE_ADDR = 5;
   localparam logic [1:0] DMEM_RSIZE_WORD = 2'b10;

   typedef logic [3:0] dump_state_t;
   localparam dump_state_t ST_IDLE       = 4'd0;
   localparam dump_state_t ST_PC         = 4'd1;
   localparam dump_state_t ST_REG_RD     = 4'd2;
   localparam dump_state_t ST_REG_CAP    = 4'd3;
   localparam dump_state_t ST_REG_SEND   = 4'd4;
   localparam dump_state_t ST_DMEM_RD    = 4'd5;
   localparam dump_state_t ST_DMEM_CAP   = 4'd6;
   localparam dump_state_t ST_DMEM_SEND  = 4'd7;
   localparam dump_state_t ST_CKSUM      = 4'd8;
   localparam dump_state_t ST_CKSUM_SEND = 4'd9;
   localparam dump_state_t ST_DONE       = 4'd10;

   typedef logic [1:0] ser_state_t;
   localparam ser_state_t SER_IDLE    = 2'd0;
   localparam ser_state_t SER_TX_BYTE = 2'd1;
   localparam ser_state_t SER_TX_WAIT = 2'd2;

endpackage

// File: rtl/dump_word_serializer.sv
// Sends one loaded 32-bit word LSB-byte-first over the UART TX handshake.
// i_single sends only the low byte (used for the trailing checksum byte).
module dump_word_serializer
   import debug_dump_pkg::*;
(
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic               i_load,
   input  logic [NB_WORD-1:0] i_word,
   input  logic               i_single,
   input  logic               i_tx_done,
   output logic               o_tx_start,
   output logic [NB_BYTE-1:0] o_wdata,
   output logic               o_word_done
);

   ser_state_t         state_q, state_d;
   logic [NB_WORD-1:0] word_q, word_d;
   logic [1:0]         byte_cnt_q, byte_cnt_d;
   logic [1:0]         last_q, last_d;

   // NOTE: flops take non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= SER_IDLE;
         word_q     <= '0;
         byte_cnt_q <= '0;
         last_q     <= '0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         byte_cnt_q <= byte_cnt_d;
         last_q     <= last_d;
      end
   end

   // NOTE: defaults first so no path leaves a variable unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      byte_cnt_d = byte_cnt_q;
      last_d     = last_q;
      case (state_q)
         SER_IDLE: begin
            if (i_load) begin
               word_d     = i_word;
               byte_cnt_d = '0;
               last_d     = i_single ? 2'd0 : 2'(WORD_BYTES - 1);
               state_d    = SER_TX_BYTE;
            end
         end
         SER_TX_BYTE: state_d = SER_TX_WAIT;
         SER_TX_WAIT: begin
            if (i_tx_done) begin
               word_d     = word_q >> NB_BYTE;
               byte_cnt_d = byte_cnt_q + 2'd1;
               state_d    = (byte_cnt_q == last_q) ? SER_IDLE : SER_TX_BYTE;
            end
         end
         default: state_d = SER_IDLE;
      endcase
   end

   // The byte on o_wdata stays put through TX_WAIT because the shift only happens on i_tx_done.
   always_comb begin
      o_tx_start  = (state_q == SER_TX_BYTE);
      o_wdata     = word_q[NB_BYTE-1:0];
      o_word_done = (state_q == SER_TX_WAIT) && i_tx_done && (byte_cnt_q == last_q);
   end

endmodule

// File: rtl/debug_dump_sequencer.sv
// Dumps PC, regfile and DMEM words over UART once started; bytes go out via dump_word_serializer.
// Optional DUMP_CHECKSUM_EN appends one XOR byte of everything transmitted.
module debug_dump_sequencer
   import debug_dump_pkg::*;
#(
   parameter int NB_PC        = 32,
   parameter int NB_REG       = 32,
   parameter int NB_DATA      = 32,
   parameter int NB_UART_DATA = 8,
   parameter int N_REGS       = 32,
   parameter int DMEM_WORDS   = 32
) (
   input  logic                       clk,
   input  logic                       i_rst_n,
   input  logic                       i_start,
   input  logic [NB_PC-1:0]           i_pc,
   output logic                       o_regfile_rd,
   output logic [NB_REGFILE_ADDR-1:0] o_regfile_raddr,
   input  logic [NB_REG-1:0]          i_regfile_data,
   output logic                       o_dmem_rd,
   output logic [1:0]                 o_dmem_rsize,
   output logic [NB_DATA-1:0]         o_dmem_raddr,
   input  logic [NB_DATA-1:0]         i_dmem_data,
   output logic                       o_tx_start,
   output logic [NB_UART_DATA-1:0]    o_wdata,
   input  logic                       i_tx_done,
   output logic                       o_busy,
   output logic                       o_done
);

   localparam logic [NB_REGFILE_ADDR-1:0] REG_LAST  = NB_REGFILE_ADDR'(N_REGS - 1);
   localparam logic [NB_DATA-1:0]         DMEM_LAST = NB_DATA'((DMEM_WORDS > 0) ? DMEM_WORDS - 1 : 0);
`ifdef DUMP_CHECKSUM_EN
   localparam dump_state_t ST_AFTER_DATA = ST_CKSUM;
`else
   localparam dump_state_t ST_AFTER_DATA = ST_DONE;
`endif
   localparam dump_state_t ST_AFTER_REGS = (DMEM_WORDS == 0) ? ST_AFTER_DATA : ST_DMEM_RD;

   dump_state_t                state_q, state_d;
   logic [NB_REGFILE_ADDR-1:0] reg_cnt_q, reg_cnt_d;
   logic [NB_DATA-1:0]         dmem_cnt_q, dmem_cnt_d;

   logic               ser_load;
   logic [NB_WORD-1:0] ser_word;
   logic               ser_single;
   logic               ser_tx_start;
   logic [NB_BYTE-1:0] ser_wdata;
   logic               ser_word_done;

   dump_word_serializer u_serializer (
      .clk         (clk),
      .i_rst_n     (i_rst_n),
      .i_load      (ser_load),
      .i_word      (ser_word),
      .i_single    (ser_single),
      .i_tx_done   (i_tx_done),
      .o_tx_start  (ser_tx_start),
      .o_wdata     (ser_wdata),
      .o_word_done (ser_word_done)
   );

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         reg_cnt_q  <= '0;
         dmem_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         reg_cnt_q  <= reg_cnt_d;
         dmem_cnt_q <= dmem_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      reg_cnt_d  = reg_cnt_q;
      dmem_cnt_d = dmem_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               state_d    = ST_PC;
               reg_cnt_d  = '0;
               dmem_cnt_d = '0;
            end
         end
         ST_PC:      if (ser_word_done) state_d = ST_REG_RD;
         ST_REG_RD:  state_d = ST_REG_CAP;
         ST_REG_CAP: state_d = ST_REG_SEND;
         ST_REG_SEND: begin
            if (ser_word_done) begin
               if (reg_cnt_q == REG_LAST) begin
                  state_d = ST_AFTER_REGS;
               end else begin
                  reg_cnt_d = reg_cnt_q + 1'b1;
                  state_d   = ST_REG_RD;
               end
            end
         end
         ST_DMEM_RD:  state_d = ST_DMEM_CAP;
         ST_DMEM_CAP: state_d = ST_DMEM_SEND;
         ST_DMEM_SEND: begin
            if (ser_word_done) begin
               if (dmem_cnt_q == DMEM_LAST) begin
                  state_d = ST_AFTER_DATA;
               end else begin
                  dmem_cnt_d = dmem_cnt_q + 1'b1;
                  state_d    = ST_DMEM_RD;
               end
            end
         end
`ifdef DUMP_CHECKSUM_EN
         ST_CKSUM:      state_d = ST_CKSUM_SEND;
         ST_CKSUM_SEND: if (ser_word_done) state_d = ST_DONE;
`endif
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef DUMP_CHECKSUM_EN
   logic [NB_BYTE-1:0] cksum_q, cksum_d;

   always_comb begin
      cksum_d = cksum_q;
      if (state_q == ST_IDLE && i_start) cksum_d = '0;
      else if (ser_tx_start)             cksum_d = cksum_q ^ ser_wdata;
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) cksum_q <= '0;
      else          cksum_q <= cksum_d;
   end
`endif

   // Read addresses are gated so the address buses idle at zero between strobes.
   always_comb begin
      ser_load        = 1'b0;
      ser_word        = '0;
      ser_single      = 1'b0;
      o_regfile_rd    = 1'b0;
      o_regfile_raddr = '0;
      o_dmem_rd       = 1'b0;
      o_dmem_raddr    = '0;
      case (state_q)
         ST_IDLE: begin
            ser_load = i_start;
            ser_word = NB_WORD'(i_pc);
         end
         ST_REG_RD: begin
            o_regfile_rd    = 1'b1;
            o_regfile_raddr = reg_cnt_q;
         end
         ST_REG_CAP: begin
            ser_load = 1'b1;
            ser_word = NB_WORD'(i_regfile_data);
         end
         ST_DMEM_RD: begin
            o_dmem_rd    = 1'b1;
            o_dmem_raddr = dmem_cnt_q << 2;
         end
         ST_DMEM_CAP: begin
            ser_load = 1'b1;
            ser_word = NB_WORD'(i_dmem_data);
         end
`ifdef DUMP_CHECKSUM_EN
         ST_CKSUM: begin
            ser_load   = 1'b1;
            ser_single = 1'b1;
            ser_word   = NB_WORD'(cksum_q);
         end
`endif
         default: ;
      endcase
   end

   assign o_dmem_rsize = DMEM_RSIZE_WORD;
   assign o_tx_start   = ser_tx_start;
   assign o_wdata      = NB_UART_DATA'(ser_wdata);
   assign o_busy       = (state_q != ST_IDLE);
   assign o_done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Self-checking bench: a byte-stream model built from the dump rules, plus a UART and
// memory responder that check every transmitted byte and every read address.
module tb_debug_dump_sequencer;

   localparam int N_REGS     = 32;
   localparam int DMEM_WORDS = 2;
`ifdef DUMP_CHECKSUM_EN
   localparam int CK_BYTES = 1;
`else
   localparam int CK_BYTES = 0;
`endif
   localparam int EXP_TOTAL = 4 * (1 + N_REGS + DMEM_WORDS) + CK_BYTES;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [31:0] pc = '0;
   logic        regfile_rd;
   logic [4:0]  regfile_raddr;
   logic [31:0] regfile_data = '0;
   logic        dmem_rd;
   logic [1:0]  dmem_rsize;
   logic [31:0] dmem_raddr;
   logic [31:0] dmem_data = '0;
   logic        tx_start;
   logic [7:0]  wdata;
   logic        uart_done = 1'b0;
   logic        stray_done = 1'b0;
   logic        tx_done;
   logic        busy;
   logic        done;

   assign tx_done = uart_done | stray_done;

   always #5 clk = ~clk;

   debug_dump_sequencer #(
      .N_REGS     (N_REGS),
      .DMEM_WORDS (DMEM_WORDS)
   ) dut (
      .clk             (clk),
      .i_rst_n         (rst_n),
      .i_start         (start),
      .i_pc            (pc),
      .o_regfile_rd    (regfile_rd),
      .o_regfile_raddr (regfile_raddr),
      .i_regfile_data  (regfile_data),
      .o_dmem_rd       (dmem_rd),
      .o_dmem_rsize    (dmem_rsize),
      .o_dmem_raddr    (dmem_raddr),
      .i_dmem_data     (dmem_data),
      .o_tx_start      (tx_start),
      .o_wdata         (wdata),
      .i_tx_done       (tx_done),
      .o_busy          (busy),
      .o_done          (done)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Model of the core's state and of the byte stream the dump must produce.
   logic [31:0] regs [N_REGS];
   logic [31:0] mem  [DMEM_WORDS];
   logic [7:0]  exp_q [$];
   logic [7:0]  rx_log [$];

   // Counters only ever grow; each dump measures against bases taken at its start.
   int rx_cnt = 0, reg_reads = 0, dmem_reads = 0, done_cnt = 0;
   int rx_base = 0, reg_base = 0, dmem_base = 0, done_base = 0;
   int stall_idx = -1;
   bit spam_stray = 1'b0;
   bit pending = 1'b0;

   task automatic build_expected();
      logic [7:0] x;
      exp_q.delete();
      for (int b = 0; b < 4; b++) exp_q.push_back(pc[8*b +: 8]);
      for (int r = 0; r < N_REGS; r++)
         for (int b = 0; b < 4; b++) exp_q.push_back(regs[r][8*b +: 8]);
      for (int m = 0; m < DMEM_WORDS; m++)
         for (int b = 0; b < 4; b++) exp_q.push_back(mem[m][8*b +: 8]);
      x = '0;
      foreach (exp_q[i]) x = x ^ exp_q[i];
      if (CK_BYTES == 1) exp_q.push_back(x);
   endtask

   function automatic logic [7:0] rx_at(input int i);
      if (rx_base + i < rx_log.size()) return rx_log[rx_base + i];
      return 8'hxx;
   endfunction

   // UART side: record and check each byte, hold off i_tx_done for a per-byte delay.
   logic [7:0] held;
   int         wait_cnt;
   bit         hold_err;

   always @(negedge clk) begin : uart_model
      int idx;
      uart_done = 1'b0;
      if (!rst_n) begin
         pending = 1'b0;
      end else begin
         if (tx_start) begin
            idx = rx_cnt - rx_base;
            check("tx_start_while_waiting", 32'(pending), 32'd0);
            if (idx < exp_q.size()) check($sformatf("byte_%0d", idx), 32'(wdata), 32'(exp_q[idx]));
            else                    check("byte_beyond_end", idx, exp_q.size());
            rx_log.push_back(wdata);
            rx_cnt++;
            pending  = 1'b1;
            held     = wdata;
            hold_err = 1'b0;
            wait_cnt = (idx == stall_idx) ? 1000 : (idx % 3);
         end else if (pending) begin
            if (wdata !== held || regfile_rd || dmem_rd || tx_start) hold_err = 1'b1;
            if (wait_cnt == 0) begin
               check("byte_held_no_reads_while_waiting", 32'(hold_err), 32'd0);
               uart_done = 1'b1;
               pending   = 1'b0;
            end else begin
               wait_cnt--;
            end
         end
         if (done) begin
            done_cnt++;
            check("done_after_last_byte", rx_cnt - rx_base, exp_q.size());
            check("done_nothing_pending", 32'(pending), 32'd0);
         end
      end
   end

   // Core side: read data appears only in the cycle after the strobe.
   bit          reg_pend = 1'b0, dmem_pend = 1'b0;
   logic [4:0]  reg_pend_addr;
   int          dmem_pend_idx;

   always @(negedge clk) begin : mem_model
      stray_done   = 1'b0;
      regfile_data = reg_pend ? regs[reg_pend_addr] : 32'hBAD0_0BAD;
      dmem_data    = (dmem_pend && dmem_pend_idx < DMEM_WORDS) ? mem[dmem_pend_idx] : 32'hBAD1_1BAD;
      reg_pend     = 1'b0;
      dmem_pend    = 1'b0;
      if (rst_n && regfile_rd) begin
         check("regfile_raddr", 32'(regfile_raddr), reg_reads - reg_base);
         reg_pend      = 1'b1;
         reg_pend_addr = regfile_raddr;
         reg_reads++;
         if (spam_stray) stray_done = 1'b1;
      end
      if (rst_n && dmem_rd) begin
         check("dmem_raddr", dmem_raddr, 4 * (dmem_reads - dmem_base));
         check("dmem_rsize", 32'(dmem_rsize), 32'd2);
         dmem_pend     = 1'b1;
         dmem_pend_idx = int'(dmem_raddr >> 2);
         dmem_reads++;
      end
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_tx_start"},      32'(tx_start),      32'd0);
      check({tag, "_wdata"},         32'(wdata),         32'd0);
      check({tag, "_regfile_rd"},    32'(regfile_rd),    32'd0);
      check({tag, "_regfile_raddr"}, 32'(regfile_raddr), 32'd0);
      check({tag, "_dmem_rd"},       32'(dmem_rd),       32'd0);
      check({tag, "_dmem_raddr"},    dmem_raddr,         32'd0);
      check({tag, "_dmem_rsize"},    32'(dmem_rsize),    32'd2);
      check({tag, "_busy"},          32'(busy),          32'd0);
      check({tag, "_done"},          32'(done),          32'd0);
   endtask

   // stop_at < 0 runs to completion; otherwise returns once that many bytes are acknowledged.
   task automatic run_dump(input bit spam, input int stop_at);
      bit stopped;
      stopped   = 1'b0;
      rx_base   = rx_cnt;
      reg_base  = reg_reads;
      dmem_base = dmem_reads;
      done_base = done_cnt;
      build_expected();
      @(negedge clk); #1 start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      spam_stray = spam;
      for (int cyc = 0; cyc < 20000 && done_cnt == done_base; cyc++) begin
         @(negedge clk); #1;
         if (stop_at >= 0 && rx_cnt - rx_base == stop_at && !pending) begin
            stopped = 1'b1;
            break;
         end
         start = spam && ((cyc % 97) == 5 || (uart_done && rx_cnt - rx_base == exp_q.size()));
      end
      start      = 1'b0;
      spam_stray = 1'b0;
      if (stop_at >= 0) begin
         check("reached_stop_point", 32'(stopped), 32'd1);
      end else begin
         check("dump_completed", done_cnt - done_base, 32'd1);
         repeat (10) @(negedge clk);
         #1;
         check("total_bytes",   rx_cnt - rx_base,       EXP_TOTAL);
         check("done_pulses",   done_cnt - done_base,   32'd1);
         check("idle_after",    32'(busy),              32'd0);
         check("regfile_reads", reg_reads - reg_base,   N_REGS);
         check("dmem_reads",    dmem_reads - dmem_base, DMEM_WORDS);
      end
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #2;
      check_idle_outputs("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check_idle_outputs("idle");

      // Rn = n, two DMEM words, one 1000-cycle stall, stray i_start / i_tx_done.
      pc = 32'h0000_0040;
      for (int i = 0; i < N_REGS; i++) regs[i] = 32'(i);
      mem[0] = 32'hDEAD_BEEF;
      mem[1] = 32'h1234_5678;
      stall_idx = 50;
      run_dump(1'b1, -1);
      check("pc_b0", 32'(rx_at(0)), 32'h40);
      check("pc_b1", 32'(rx_at(1)), 32'h00);
      check("pc_b3", 32'(rx_at(3)), 32'h00);
      check("r0_b0", 32'(rx_at(4)), 32'h00);
      check("r1_b0", 32'(rx_at(8)), 32'h01);
      check("m0_b0", 32'(rx_at(132)), 32'hEF);
      check("m0_b1", 32'(rx_at(133)), 32'hBE);
      check("m0_b2", 32'(rx_at(134)), 32'hAD);
      check("m0_b3", 32'(rx_at(135)), 32'hDE);
      check("total_literal", rx_cnt - rx_base, 32'(140 + CK_BYTES));

      // Reset after R3 has gone out, then a fresh dump must restart at the PC.
      stall_idx = -1;
      run_dump(1'b0, 20);
      @(posedge clk);
      #2;
      check("busy_before_reset", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("mid_reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      pc = 32'h0102_0304;
      for (int i = 0; i < N_REGS; i++) regs[i] = '0;
      for (int i = 0; i < DMEM_WORDS; i++) mem[i] = '0;
      run_dump(1'b0, -1);
      check("restart_pc_b0", 32'(rx_at(0)), 32'h04);
      check("restart_pc_b1", 32'(rx_at(1)), 32'h03);
      check("restart_pc_b2", 32'(rx_at(2)), 32'h02);
      check("restart_pc_b3", 32'(rx_at(3)), 32'h01);
`ifdef DUMP_CHECKSUM_EN
      check("checksum_byte", 32'(rx_at(140)), 32'h04);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
